// File: rtl/lock_pkg.sv
// Shared types and defaults for the keyed lock block: FSM state encoding,
// default geometry/key, and the key-bit to data-bit fold mapping.
package lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } lock_state_e;

  localparam int          DEF_DATA_W      = 4;
  localparam int          DEF_KEY_W       = 3;
  localparam logic [2:0]  DEF_CORRECT_KEY = 3'b010;

  // Key bit i gates data bit (i mod data_w); wider keys wrap around.
  function automatic int unsigned fold_index(input int unsigned i,
                                             input int unsigned data_w);
    return i % data_w;
  endfunction

endpackage

// File: rtl/key_shift_loader.sv
// Serial key loader: assembles KEY_W bits (LSB first) in a shadow register
// and commits them to key_reg only when the last bit arrives, so the active
// key never exposes a partially loaded value.
module key_shift_loader
  import lock_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic             key_bit,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_reg,
  output logic             key_loaded,
  output logic             load_busy
);

  localparam int                CNT_W    = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(KEY_W - 1);

  lock_state_e      state, state_next;
  logic [KEY_W-1:0] shadow, shadow_next, shifted;
  logic [KEY_W-1:0] key_next;
  logic [CNT_W-1:0] bit_cnt, cnt_next, cnt_base;

  // Next-state, shadow shift and key commit decisions.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_next  = state;
    shadow_next = shadow;
    cnt_next    = bit_cnt;
    key_next    = key_reg;
    // A load started from IDLE or ARMED counts from zero.
    cnt_base    = (state == ST_LOAD) ? bit_cnt : '0;
    // Right shift with the new bit entering at the top: after KEY_W shifts
    // the first accepted bit sits in bit 0.
    shifted     = (shadow >> 1) | (KEY_W'(key_bit) << (KEY_W - 1));

    if (key_clear) begin
      state_next  = ST_IDLE;
      shadow_next = '0;
      cnt_next    = '0;
      key_next    = '0;
    end else if (key_valid) begin
      shadow_next = shifted;
      if (cnt_base == LAST_CNT) begin
        state_next = ST_ARMED;
        key_next   = shifted;
        cnt_next   = '0;
      end else begin
        state_next = ST_LOAD;
        cnt_next   = cnt_base + CNT_W'(1);
      end
    end
  end

  // State and key registers; status flags follow the post-edge state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      shadow     <= '0;
      bit_cnt    <= '0;
      key_reg    <= '0;
      key_loaded <= 1'b0;
      load_busy  <= 1'b0;
    end else begin
      state      <= state_next;
      shadow     <= shadow_next;
      bit_cnt    <= cnt_next;
      key_reg    <= key_next;
      key_loaded <= (state_next == ST_ARMED);
      load_busy  <= (state_next == ST_LOAD);
    end
  end

endmodule

// File: rtl/keyed_lock_core.sv
// Keyed lock core: XOR key gates on the data inputs, a pairwise AND/OR
// function behind them, and a one-cycle registered result with valid.
module keyed_lock_core
  import lock_pkg::*;
#(
  parameter int               DATA_W      = DEF_DATA_W,
  parameter int               KEY_W       = DEF_KEY_W,
  parameter logic [KEY_W-1:0] CORRECT_KEY = KEY_W'(DEF_CORRECT_KEY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic              key_bit,
  input  logic              key_clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic              y,
  output logic              key_loaded,
  output logic              load_busy
);

  logic [KEY_W-1:0]  key_reg;
  logic [KEY_W-1:0]  diff;
  logic [DATA_W-1:0] fold;
  logic [DATA_W-1:0] d_l;
  logic              y_next;

  key_shift_loader #(
    .KEY_W (KEY_W)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_clear  (key_clear),
    .key_reg    (key_reg),
    .key_loaded (key_loaded),
    .load_busy  (load_busy)
  );

  // Key gates: fold key mismatches onto data bits, then evaluate the
  // OR of adjacent-pair ANDs. The correct key makes every gate transparent.
  always_comb begin
    diff = key_reg ^ CORRECT_KEY;
    fold = '0;
    for (int j = 0; j < DATA_W; j++) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (fold_index(i, DATA_W) == j) fold[j] = fold[j] ^ diff[i];
      end
    end
    d_l    = data_in ^ fold;
    y_next = 1'b0;
    for (int p = 0; p < DATA_W / 2; p++) begin
      y_next = y_next | (d_l[2*p] & d_l[2*p+1]);
    end
  end

  // Result register: y updates only on valid input, out_valid every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) y <= y_next;
    end
  end

endmodule

// File: tb/tb_keyed_lock_core.sv
// Directed bench for keyed_lock_core: default 4/3/010 instance plus a
// 6/8/A5 instance, with hand-derived expectations checked by assertions.
module tb_keyed_lock_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid, key_bit, key_clear, in_valid;
  logic [3:0] data_in;
  logic       out_valid, y, key_loaded, load_busy;

  logic       key_valid2, key_bit2, in_valid2;
  logic [5:0] data_in2;
  logic       out_valid2, y2, key_loaded2, load_busy2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  keyed_lock_core dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_bit    (key_bit),
    .key_clear  (key_clear),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .y          (y),
    .key_loaded (key_loaded),
    .load_busy  (load_busy)
  );

  keyed_lock_core #(
    .DATA_W      (6),
    .KEY_W       (8),
    .CORRECT_KEY (8'hA5)
  ) dut_wide (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid2),
    .key_bit    (key_bit2),
    .key_clear  (1'b0),
    .in_valid   (in_valid2),
    .data_in    (data_in2),
    .out_valid  (out_valid2),
    .y          (y2),
    .key_loaded (key_loaded2),
    .load_busy  (load_busy2)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    key_valid = 1'b1;
    key_bit   = b;
    step();
    key_valid = 1'b0;
  endtask

  task automatic send_data(input logic [3:0] d);
    in_valid = 1'b1;
    data_in  = d;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic golden4(input logic [3:0] d);
    return (d[0] & d[1]) | (d[2] & d[3]);
  endfunction

  function automatic logic golden6(input logic [5:0] d);
    return (d[0] & d[1]) | (d[2] & d[3]) | (d[4] & d[5]);
  endfunction

  initial begin
    logic [7:0] k;
    rst = 1'b1; key_valid = 0; key_bit = 0; key_clear = 0; in_valid = 0; data_in = '0;
    key_valid2 = 0; key_bit2 = 0; in_valid2 = 0; data_in2 = '0;

    // Reset state
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_key_loaded", key_loaded, 0);
    check("rst_load_busy", load_busy, 0);
    rst = 1'b0;

    // No key: key_reg=0, diff=010 flips data bit 1
    send_data(4'b0011);
    check("nokey_out_valid", out_valid, 1);
    check("nokey_0011", y, 0);
    send_data(4'b0001);
    check("nokey_0001", y, 1);

    // Correct key 0,1,0
    send_bit(1'b0);
    check("load1_busy", load_busy, 1);
    check("load1_loaded", key_loaded, 0);
    send_bit(1'b1);
    check("load2_loaded", key_loaded, 0);
    send_bit(1'b0);
    check("load3_loaded", key_loaded, 1);
    check("load3_busy", load_busy, 0);
    send_data(4'b0011);
    check("good_out_valid", out_valid, 1);
    check("good_0011", y, 1);
    step();
    check("idle_out_valid", out_valid, 0);
    check("idle_y_hold", y, 1);
    for (int v = 0; v < 16; v++) begin
      send_data(4'(v));
      check($sformatf("good_sweep_%0d", v), y, golden4(4'(v)));
    end

    // Wrong key 1,0,1 -> diff=111
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("wrong_loaded", key_loaded, 1);
    send_data(4'b0011);
    check("wrong_0011", y, 0);
    send_data(4'b0100);
    check("wrong_0100", y, 1);

    // Partial load then clear; data in the clear cycle uses old key 101
    send_bit(1'b1);
    check("part_busy", load_busy, 1);
    send_bit(1'b1);
    key_clear = 1'b1; in_valid = 1'b1; data_in = 4'b0001;
    step();
    key_clear = 1'b0; in_valid = 1'b0;
    check("clear_busy", load_busy, 0);
    check("clear_loaded", key_loaded, 0);
    check("clear_prekey_y", y, 0);
    send_data(4'b0001);
    check("clear_key0_y", y, 1);

    // Partial load then reset; the next load needs all three bits
    send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_y", y, 0);
    check("rstmid_busy", load_busy, 0);
    check("rstmid_loaded", key_loaded, 0);
    send_bit(1'b0);
    check("rstload1_busy", load_busy, 1);
    send_bit(1'b1);
    check("rstload2_loaded", key_loaded, 0);
    send_bit(1'b0);
    check("rstload3_loaded", key_loaded, 1);
    send_data(4'b0011);
    check("rstload_y", y, 1);

    // key_clear together with key_valid: clear wins, bit discarded
    key_clear = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
    step();
    key_clear = 1'b0; key_valid = 1'b0;
    check("clrkv_busy", load_busy, 0);
    check("clrkv_loaded", key_loaded, 0);
    send_bit(1'b0); send_bit(1'b1);
    check("clrkv_two_loaded", key_loaded, 0);
    send_bit(1'b0);
    check("clrkv_three_loaded", key_loaded, 1);

    // Reload 1,0,1 while armed with 010
    send_bit(1'b1);
    check("reload1_loaded", key_loaded, 0);
    check("reload1_busy", load_busy, 1);
    send_bit(1'b0);
    send_data(4'b0011);
    check("reload_mid_y", y, 1);
    key_valid = 1'b1; key_bit = 1'b1; in_valid = 1'b1; data_in = 4'b0011;
    step();
    key_valid = 1'b0; in_valid = 1'b0;
    check("reload_last_y", y, 1);
    check("reload_last_loaded", key_loaded, 1);
    send_data(4'b0011);
    check("reload_new_0011", y, 0);
    send_data(4'b0100);
    check("reload_new_0100", y, 1);

    // Wide instance: correct key A5, LSB first
    k = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      key_valid2 = 1'b1; key_bit2 = k[i];
      step();
    end
    key_valid2 = 1'b0;
    check("wide_loaded", key_loaded2, 1);
    for (int v = 0; v < 64; v++) begin
      in_valid2 = 1'b1; data_in2 = 6'(v);
      step();
      check($sformatf("wide_good_%0d", v), y2, golden6(6'(v)));
    end
    in_valid2 = 1'b0;

    // Wide instance: key A4 -> diff=01, data bit 0 inverted
    k = 8'hA4;
    for (int i = 0; i < 8; i++) begin
      key_valid2 = 1'b1; key_bit2 = k[i];
      step();
    end
    key_valid2 = 1'b0;
    check("wide_a4_loaded", key_loaded2, 1);
    for (int v = 0; v < 64; v++) begin
      in_valid2 = 1'b1; data_in2 = 6'(v);
      step();
      check($sformatf("wide_a4_%0d", v), y2, golden6(6'(v) ^ 6'b000001));
    end
    in_valid2 = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/keyed_lock_core.md
Name: keyed_lock_core

Overview:
- Sequential, parametrised successor to the team's 4-input/3-key XOR-locked gate-level function.
- Data width and key width are parameters. The embedded correct key is a parameter.
- The key is loaded serially through a load state machine, not applied on static pins.
- The locked function output is registered behind a valid handshake. The block sits between the key-provisioning path and the locked datapath under verification.

Parameters:
- DATA_W, 4, data input width; must be even and at least 2.
- KEY_W, 3, key width; 1 to 64.
- CORRECT_KEY, 3'b010, unlocking key; bit i pairs with key-gate i.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- key_valid  in  1  key_bit is presented this cycle
- key_bit  in  1  serial key bit, LSB first
- key_clear  in  1  discard key, return to IDLE
- in_valid  in  1  data_in is valid
- data_in  in  DATA_W  functional inputs
- out_valid  out  1  y is valid
- y  out  1  locked function result
- key_loaded  out  1  high in ARMED
- load_busy  out  1  high in LOAD

Behaviour:
- Reset: all of the following go to 0 on the clock edge with rst=1:
  - state becomes IDLE
  - key_reg, shadow and bit_cnt
  - out_valid, y, key_loaded and load_busy
- Reset mid-load abandons the partial key.
- FSM states are IDLE, LOAD and ARMED.
  - IDLE: key_valid goes to LOAD. The bit is captured and bit_cnt becomes 1.
  - LOAD: each key_valid shifts key_bit into shadow and increments bit_cnt. Cycles without key_valid hold state with no timeout.
  - LOAD to ARMED: on the cycle the KEY_W-th bit is accepted, key_reg takes the full shadow value including that bit, and bit_cnt clears.
  - KEY_W=1: IDLE goes directly to ARMED on the first key_valid.
  - ARMED: key_valid starts a new LOAD. key_reg keeps the old key until the new load completes.
- key_clear in any state: state IDLE, key_reg=0, bit_cnt=0.
  - key_clear has priority over key_valid in the same cycle.
  - rst has priority over everything.
- Key assembly: the first accepted bit lands in key_reg[0] and the last in key_reg[KEY_W-1].
- Key gates:
  - diff = key_reg XOR CORRECT_KEY.
  - d_l[j] = data_in[j] XOR (XOR of diff[i] over all i where i mod DATA_W = j).
  - When KEY_W > DATA_W, multiple key bits fold onto one data bit.
- Function: y_next = OR over p = 0..DATA_W/2-1 of (d_l[2p] AND d_l[2p+1]).
  - With the correct key, y = golden function of data_in.
- Key state in IDLE and LOAD: key_reg is 0 after reset or clear, so IDLE is locked unless CORRECT_KEY=0. Data processed during LOAD uses the current key_reg, not shadow.
- Latency is 1 cycle:
  - in_valid=1 at edge N gives out_valid=1 and y valid after edge N.
  - in_valid=0 gives out_valid=0 next cycle; y holds its last value.
  - There is no backpressure; one result per cycle.
- Simultaneous events:
  - in_valid in the same cycle as the final key bit uses the old key_reg.
  - in_valid in the same cycle as key_clear uses the pre-clear key_reg.
- key_loaded and load_busy are registered and reflect the state after each edge.

Decomposition:
- Package lock_pkg holds:
  - the state enum (IDLE, LOAD, ARMED)
  - default DATA_W, KEY_W and CORRECT_KEY constants
  - a function computing the fold mapping i mod DATA_W
- Sub-module key_shift_loader holds the FSM, shadow, bit_cnt and key_reg, and outputs key_reg, key_loaded and load_busy.
- The top level holds the key-gate XOR network, the pair-AND/OR function and the output register.

Test Plan:
- Defaults. After reset, load 0,1,0 over three cycles. Then data_in=4'b0011:
  - key_loaded=1 after the third bit
  - one cycle after in_valid, out_valid=1 and y=1
  - all 16 data values match the golden (d0&d1)|(d2&d3)
- Wrong key. Load 1,0,1 (diff=3'b111). data_in=4'b0011 gives y=0. data_in=4'b0100 gives y=1.
- No key. After reset (key_reg=0, diff=3'b010), data_in=4'b0011 gives y=0 and data_in=4'b0001 gives y=1.
- Load interrupts:
  - Load two bits, then assert key_clear: state IDLE, load_busy=0, key_reg=0.
  - Repeat with rst instead: all outputs 0.
  - key_clear together with key_valid: clear wins.
- Reload. While ARMED with 010, start loading 101 and send data after two bits:
  - results still use 010, and key_loaded=0 during LOAD
  - data sampled in the same cycle as the third bit uses 010
  - data on the next cycle uses 101
- Parameter sweep. DATA_W=6, KEY_W=8, CORRECT_KEY=8'hA5 with the correct key: y equals the golden function for all 64 inputs. Key 8'hA4 gives diff=8'h01, which flips d bit 0; check y against the bench model.
